// File: rtl/time_set_ctrl.sv
// Timekeeping / time-setting controller: RUN advances hh:mm:ss on the 1 Hz tick,
// SET edits the selected field and blinks it. Optional macro SET_TIMEOUT_EN adds SET auto-exit.
module time_set_ctrl #(
  parameter int unsigned BLINK_CYCLES  = 50_000_000,
  parameter int unsigned TIMEOUT_TICKS = 10
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_tick_1hz,
  input  logic       i_mode_pulse,
  input  logic [1:0] i_sel,
  input  logic       i_inc_pulse,
  input  logic       i_dec_pulse,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic       o_setting,
  output logic [2:0] o_blank,
  output logic       o_rollover
);

  typedef enum logic {ST_RUN = 1'b0, ST_SET = 1'b1} state_t;

  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
    return (v >= max_v) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max_v);
    return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

  state_t               state_q, state_d;
  logic [4:0]           hours_q, hours_d;
  logic [5:0]           minutes_q, minutes_d;
  logic [5:0]           seconds_q, seconds_d;
  logic                 rollover_q, rollover_d;
  logic [2:0]           blank_q, blank_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  logic [1:0]           sel_q;
  logic                 activity;
  logic                 timeout_hit;

  // Any edit pulse or field reselection restarts both the blink and the timeout.
  assign activity = i_inc_pulse | i_dec_pulse | (i_sel != sel_q);

`ifdef SET_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d    = to_cnt_q;
    timeout_hit = 1'b0;
    if (state_q != ST_SET || activity) begin
      to_cnt_d = '0;
    end else if (i_tick_1hz) begin
      if (to_cnt_q == TO_LAST) begin
        timeout_hit = 1'b1;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) to_cnt_q <= '0;
    else            to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_RUN;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (i_mode_pulse) state_d = ST_SET;
      ST_SET:  if (i_mode_pulse || timeout_hit) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Time fields: carry chain in RUN, independent per-field wrap in SET.
  always_comb begin
    hours_d    = hours_q;
    minutes_d  = minutes_q;
    seconds_d  = seconds_q;
    rollover_d = 1'b0;
    if (state_q == ST_RUN) begin
      if (i_tick_1hz) begin
        seconds_d = wrap_inc(seconds_q, 6'd59);
        if (seconds_q == 6'd59) begin
          minutes_d = wrap_inc(minutes_q, 6'd59);
          if (minutes_q == 6'd59) begin
            hours_d    = 5'(wrap_inc({1'b0, hours_q}, 6'd23));
            rollover_d = (hours_q == 5'd23);
          end
        end
      end
    end else if (i_inc_pulse != i_dec_pulse) begin
      case (i_sel)
        2'd0: seconds_d = i_inc_pulse ? wrap_inc(seconds_q, 6'd59) : wrap_dec(seconds_q, 6'd59);
        2'd1: minutes_d = i_inc_pulse ? wrap_inc(minutes_q, 6'd59) : wrap_dec(minutes_q, 6'd59);
        2'd2: hours_d   = i_inc_pulse ? 5'(wrap_inc({1'b0, hours_q}, 6'd23))
                                      : 5'(wrap_dec({1'b0, hours_q}, 6'd23));
        default: begin end
      endcase
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    phase_d     = phase_q;
    if (state_q != ST_SET || state_d != ST_SET || activity) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Blank is computed from next-state values so it lands on the same edge as the phase flip.
  always_comb begin
    blank_d = 3'b000;
    if (state_d == ST_SET && phase_d && i_sel != 2'd3) blank_d = 3'b001 << i_sel;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hours_q     <= '0;
      minutes_q   <= '0;
      seconds_q   <= '0;
      rollover_q  <= 1'b0;
      blank_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      sel_q       <= '0;
    end else begin
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      rollover_q  <= rollover_d;
      blank_q     <= blank_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      sel_q       <= i_sel;
    end
  end

  assign o_hours    = hours_q;
  assign o_minutes  = minutes_q;
  assign o_seconds  = seconds_q;
  assign o_setting  = (state_q == ST_SET);
  assign o_blank    = blank_q;
  assign o_rollover = rollover_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed steps plus random traffic against a
// total-seconds / elapsed-cycles reference model.
module tb_time_set_ctrl;

  localparam int BLINK = 4;
  localparam int TMO   = 3;

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic       i_tick_1hz, i_mode_pulse, i_inc_pulse, i_dec_pulse;
  logic [1:0] i_sel;
  logic [4:0] o_hours;
  logic [5:0] o_minutes, o_seconds;
  logic       o_setting, o_rollover;
  logic [2:0] o_blank;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  int m_t;        // time of day in seconds, 0..86399
  bit m_set;
  int m_k;        // clocks since the blink last restarted
  int m_to;       // idle ticks seen in SET
  int m_selprev;
  int e_roll;
  int e_blank;

  time_set_ctrl #(.BLINK_CYCLES(BLINK), .TIMEOUT_TICKS(TMO)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_tick_1hz(i_tick_1hz),
    .i_mode_pulse(i_mode_pulse), .i_sel(i_sel), .i_inc_pulse(i_inc_pulse),
    .i_dec_pulse(i_dec_pulse), .o_hours(o_hours), .o_minutes(o_minutes),
    .o_seconds(o_seconds), .o_setting(o_setting), .o_blank(o_blank),
    .o_rollover(o_rollover)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_set = 0; m_k = 0; m_to = 0; m_selprev = 0; e_roll = 0; e_blank = 0;
  endtask

  task automatic model_edge(input bit tk, input bit md, input int sl, input bit in, input bit de);
    bit edit, selchg, leave, new_set;
    int h, mi, s, d;
    edit   = in | de;
    selchg = (sl != m_selprev);
    e_roll = 0;
    if (!m_set) begin
      if (tk) begin
        m_t = (m_t + 1) % 86400;
        if (m_t == 0) e_roll = 1;
      end
    end else if (in != de && sl != 3) begin
      h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
      d = in ? 1 : -1;
      if (sl == 0) s  = (s + d + 60) % 60;
      if (sl == 1) mi = (mi + d + 60) % 60;
      if (sl == 2) h  = (h + d + 24) % 24;
      m_t = h * 3600 + mi * 60 + s;
    end
    leave = md;
`ifdef SET_TIMEOUT_EN
    if (!m_set || edit || selchg) m_to = 0;
    else if (tk) begin
      m_to++;
      if (m_to == TMO) begin leave = 1; m_to = 0; end
    end
`endif
    new_set = m_set ? !leave : md;
    if (!m_set || !new_set || edit || selchg) m_k = 0;
    else m_k++;
    e_blank = (new_set && sl != 3 && ((m_k / BLINK) % 2 == 1)) ? (1 << sl) : 0;
    m_selprev = sl;
    m_set = new_set;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_hours"},   o_hours,    m_t / 3600);
    chk({tag, "_minutes"}, o_minutes,  (m_t / 60) % 60);
    chk({tag, "_seconds"}, o_seconds,  m_t % 60);
    chk({tag, "_setting"}, o_setting,  int'(m_set));
    chk({tag, "_blank"},   o_blank,    e_blank);
    chk({tag, "_rollover"}, o_rollover, e_roll);
  endtask

  task automatic step(input string tag, input bit tk, input bit md, input int sl,
                      input bit in, input bit de);
    i_tick_1hz = tk; i_mode_pulse = md; i_sel = 2'(sl);
    i_inc_pulse = in; i_dec_pulse = de;
    @(posedge clk); #1;
    model_edge(tk, md, sl, in, de);
    i_tick_1hz = 0; i_mode_pulse = 0; i_inc_pulse = 0; i_dec_pulse = 0;
    check_outputs(tag);
  endtask

  initial begin
    int sl_r;
    i_reset_n = 0; i_tick_1hz = 0; i_mode_pulse = 0; i_inc_pulse = 0;
    i_dec_pulse = 0; i_sel = 2'd0;
    model_reset();
    #22 i_reset_n = 1;
    check_outputs("reset");

    // 1: sixty ticks, then preload 23:59:59 and wrap
    for (int i = 0; i < 60; i++) step("run60", 1, 0, 0, 0, 0);
    chk("run60_min", o_minutes, 1);
    step("p_enter", 0, 1, 2, 0, 0);
    step("p_h",     0, 0, 2, 0, 1);
    step("p_m1",    0, 0, 1, 0, 1);
    step("p_m2",    0, 0, 1, 0, 1);
    step("p_s",     0, 0, 0, 0, 1);
    step("p_exit",  0, 1, 0, 0, 0);
    chk("preload_h", o_hours, 23);
    step("wrap",    1, 0, 0, 0, 0);
    chk("wrap_roll", o_rollover, 1);
    step("wrap_after", 0, 0, 0, 0, 0);

    // 2: hours edited with wrap, minutes borrow-free
    step("e_enter", 0, 1, 2, 0, 0);
    for (int i = 0; i < 25; i++) step("h_inc", 0, 0, 2, 1, 0);
    chk("h_inc_25", o_hours, 1);
    step("m_dec", 0, 0, 1, 0, 1);
    chk("m_dec_59", o_minutes, 59);

    // 3: blinking on seconds, restart on edit, none for sel 3
    for (int i = 0; i < 11; i++) step("blink", 0, 0, 0, 0, 0);
    step("blink_inc", 0, 0, 0, 1, 0);
    chk("blink_inc_clear", o_blank, 0);
    for (int i = 0; i < 9; i++) step("blink2", 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("sel3", 0, 0, 3, 0, 0);

    // 4: ticks frozen in SET, inc+dec together, mode with tick in RUN
    step("set_tick1", 1, 0, 0, 0, 0);
    step("set_tick2", 1, 0, 0, 0, 0);
    step("incdec",    0, 0, 0, 1, 1);
    step("exit4",     0, 1, 0, 0, 0);
    step("mode_tick", 1, 1, 0, 0, 0);
    chk("mode_tick_set", o_setting, 1);

`ifdef SET_TIMEOUT_EN
    // 5: idle ticks time SET out; an edit restarts the count
    step("to_sel", 0, 0, 1, 0, 0);
    step("to_t1",  1, 0, 1, 0, 0);
    step("to_t2",  1, 0, 1, 0, 0);
    step("to_inc", 0, 0, 1, 1, 0);
    step("to_t3",  1, 0, 1, 0, 0);
    step("to_t4",  1, 0, 1, 0, 0);
    chk("to_still_set", o_setting, 1);
    step("to_t5",  1, 0, 1, 0, 0);
    chk("to_exit", o_setting, 0);
    step("to_run", 1, 0, 1, 0, 0);
`endif

    // Random traffic
    sl_r = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) sl_r = int'($urandom_range(0, 3));
      step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, sl_r,
           $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
    end

    // 6: asynchronous reset mid-SET
    if (!m_set) step("r_enter", 0, 1, 0, 0, 0);
    step("r_inc", 0, 0, 0, 1, 0);
    #3 i_reset_n = 0;
    #1 model_reset();
    check_outputs("rst_async");
    @(posedge clk); #1;
    check_outputs("rst_hold");
    #2 i_reset_n = 1;
    step("post_rst1", 1, 0, 0, 0, 0);
    step("post_rst2", 1, 0, 0, 0, 0);
    chk("post_rst_sec", o_seconds, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
